// File: rtl/req_ack_pkg.sv
// ---------------------------------------------------------------------------
// req_ack_pkg
//   Shared definitions for the req/ack responder slice.
//   - MAX_LATENCY : largest supported req-to-ack distance in clocks
//   - DEF_TAG_W   : tag width of the default configuration
//   - stage_t     : one delay-line slot {vld, tag} at the default tag width
// ---------------------------------------------------------------------------
package req_ack_pkg;

    localparam int MAX_LATENCY = 16;
    localparam int DEF_TAG_W   = 4;

    typedef struct packed {
        logic                 vld;
        logic [DEF_TAG_W-1:0] tag;
    } stage_t;

endpackage

// File: rtl/req_ack_responder_if.sv
// ---------------------------------------------------------------------------
// req_ack_responder_if
//   Request/response bundle between a requester (master) and the responder
//   (slave).
//   master drives : req, req_tag, drop_inj, flush
//   slave drives  : ack, ack_tag, pending, ack_cnt, drop_cnt
// ---------------------------------------------------------------------------
interface req_ack_responder_if #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
);
    localparam int PEND_W = $clog2(LATENCY + 1);

    logic              req;
    logic [TAG_W-1:0]  req_tag;
    logic              drop_inj;
    logic              flush;
    logic              ack;
    logic [TAG_W-1:0]  ack_tag;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  ack_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output req, req_tag, drop_inj, flush,
        input  ack, ack_tag, pending, ack_cnt, drop_cnt
    );

    modport slave (
        input  req, req_tag, drop_inj, flush,
        output ack, ack_tag, pending, ack_cnt, drop_cnt
    );

endinterface

// File: rtl/req_ack_delay_line.sv
// ---------------------------------------------------------------------------
// req_ack_delay_line
//   LATENCY-deep shift register of {vld, tag} slots with a synchronous clear.
//   Slot 0 loads from the inputs every clock; each slot moves one step per
//   clock; the last slot is the registered output. count is the number of
//   valid slots, registered together with the slots themselves.
//   Ports:
//     clk      in   clock, posedge
//     clr      in   synchronous clear of every slot and of count
//     in_vld   in   valid bit entering slot 0
//     in_tag   in   tag entering slot 0
//     out_vld  out  valid bit of the last slot
//     out_tag  out  tag of the last slot
//     count    out  popcount of slot valid bits
// ---------------------------------------------------------------------------
module req_ack_delay_line
    import req_ack_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           in_vld,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_vld,
    output logic [TAG_W-1:0]               out_tag,
    output logic [$clog2(LATENCY+1)-1:0]   count
);

    localparam int PEND_W = $clog2(LATENCY + 1);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } line_t;

    line_t             stage_q [LATENCY];
    line_t             stage_d [LATENCY];
    logic [PEND_W-1:0] count_d;
    logic [PEND_W-1:0] count_q;

    // Next contents of the line; count is taken from the next contents so
    // that it lands in the same register update as the slots.
    always_comb begin
        stage_d[0] = {in_vld, in_tag};
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        count_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            count_d = count_d + PEND_W'(stage_d[i].vld);
        end
    end

    // ---- stage boundary: every slot and the count advance together ----
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            count_q <= count_d;
        end
    end

    assign out_vld = stage_q[LATENCY-1].vld;
    assign out_tag = stage_q[LATENCY-1].tag;
    assign count   = count_q;

endmodule

// File: rtl/req_ack_responder_sva.sv
// ---------------------------------------------------------------------------
// req_ack_responder_sva
//   Protocol checker bound into every req_ack_responder instance.
//   - p_req_ack : an accepted request is answered LATENCY clocks later with
//                 ack=1 and its own tag, unless a flush or reset in between
//                 legitimately discarded it.
//   - c_b2b_ack : cover for acks on two consecutive edges.
//   Ports: the responder's clk/rst and its request/response signals, all
//   inputs.
// ---------------------------------------------------------------------------
module req_ack_responder_sva #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             req,
    input logic [TAG_W-1:0] req_tag,
    input logic             drop_inj,
    input logic             flush,
    input logic             ack,
    input logic [TAG_W-1:0] ack_tag
);

    localparam int SC_W = $clog2(LATENCY + 1);

    // Edges since the last flush/reset, saturating at LATENCY. A request
    // accepted at edge k is killed exactly when a clear lands on one of
    // k+1..k+LATENCY-1, which shows up at edge k+LATENCY as a count below
    // LATENCY-1.
    logic [SC_W-1:0] since_clear;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            since_clear <= '0;
        end else if (since_clear != SC_W'(LATENCY)) begin
            since_clear <= since_clear + 1'b1;
        end
    end

    property p_req_ack;
        @(posedge clk) disable iff (rst)
        (req && !drop_inj && !flush) |-> ##LATENCY
            ((int'(since_clear) < LATENCY - 1) ||
             (ack && (ack_tag == $past(req_tag, LATENCY))));
    endproperty

    a_req_ack: assert property (p_req_ack)
        else $error("req_ack_responder: missing or mistagged ack");

    c_b2b_ack: cover property (@(posedge clk) disable iff (rst) ack ##1 ack);

endmodule

bind req_ack_responder req_ack_responder_sva #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
) u_sva (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_tag  (req_tag),
    .drop_inj (drop_inj),
    .flush    (flush),
    .ack      (ack),
    .ack_tag  (ack_tag)
);

// File: rtl/req_ack_responder.sv
// ---------------------------------------------------------------------------
// req_ack_responder
//   Responder for the "req ##LATENCY ack" handshake. Every request sampled on
//   a clock edge is answered by a one-cycle ack exactly LATENCY clocks later,
//   carrying the request's tag. Requests may arrive every cycle; there is no
//   backpressure. drop_inj suppresses the ack of the request it accompanies,
//   flush discards everything in flight (including a request on the same
//   edge), and two wrapping counters report acks issued and requests dropped.
//   Ports:
//     clk   in   clock, posedge
//     rst   in   synchronous active-high reset, overrides all other inputs
//     bus   slave modport of req_ack_responder_if:
//             req/req_tag/drop_inj/flush in,
//             ack/ack_tag/pending/ack_cnt/drop_cnt out
//   ack, ack_tag and pending come straight from registers; there is no
//   combinational path from any input to any output.
// ---------------------------------------------------------------------------
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    req_ack_responder_if.slave  bus
);

    localparam int PEND_W = $clog2(LATENCY + 1);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("req_ack_responder: LATENCY=%0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end

    logic              req;
    logic [TAG_W-1:0]  req_tag;
    logic              drop_inj;
    logic              flush;
    logic              accept;
    logic              drop_hit;
    logic              ack;
    logic [TAG_W-1:0]  line_tag;
    logic [TAG_W-1:0]  ack_tag;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  ack_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    assign req      = bus.req;
    assign req_tag  = bus.req_tag;
    assign drop_inj = bus.drop_inj;
    assign flush    = bus.flush;

    // A dropped request still occupies a slot, but with vld=0, so it never
    // produces an ack. A flush on the same edge discards the request
    // outright, which is why it is neither accepted nor counted as dropped.
    assign accept   = req & ~drop_inj & ~flush;
    assign drop_hit = req &  drop_inj & ~flush;

    req_ack_delay_line #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_line (
        .clk     (clk),
        .clr     (rst | flush),
        .in_vld  (accept),
        .in_tag  (req_tag),
        .out_vld (ack),
        .out_tag (line_tag),
        .count   (pending)
    );

    // ---- stage boundary: counters update on the edge that samples ack ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            ack_cnt_q  <= ack_cnt_q  + CNT_W'(ack);
            drop_cnt_q <= drop_cnt_q + CNT_W'(drop_hit);
        end
    end

    // Dropped slots carry their tag down the line; masking here keeps a
    // stale tag from ever appearing while ack is low.
    assign ack_tag = ack ? line_tag : '0;

    assign bus.ack      = ack;
    assign bus.ack_tag  = ack_tag;
    assign bus.pending  = pending;
    assign bus.ack_cnt  = ack_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// ---------------------------------------------------------------------------
// tb_req_ack_responder
//   Directed bench for req_ack_responder (LATENCY=2, TAG_W=4, CNT_W=16).
//   A queue model of outstanding requests (each with the edge on which its
//   ack is due) predicts every output after every edge; hand-computed
//   literal checks at chosen edges pin the model. Edge n is the n-th posedge.
// ---------------------------------------------------------------------------
module tb_req_ack_responder;

    localparam int L     = 2;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;

    req_ack_responder_if #(.LATENCY(L), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    req_ack_responder #(
        .LATENCY (L),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s after edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
    } ev_t;

    ev_t              evq[$];
    logic [CNT_W-1:0] m_ack_cnt  = '0;
    logic [CNT_W-1:0] m_drop_cnt = '0;
    logic             exp_ack    = 1'b0;
    logic [TAG_W-1:0] exp_tag    = '0;
    int               exp_pend   = 0;

    always @(posedge clk) begin
        bit acked;
        edge_n++;
        acked = (evq.size() != 0) && (evq[0].due == edge_n);
        if (acked) void'(evq.pop_front());
        if (rst) begin
            evq.delete();
            m_ack_cnt  = '0;
            m_drop_cnt = '0;
        end else begin
            if (acked) m_ack_cnt = m_ack_cnt + 1'b1;
            if (bus.flush) begin
                evq.delete();
            end else if (bus.req) begin
                if (bus.drop_inj) m_drop_cnt = m_drop_cnt + 1'b1;
                else evq.push_back('{due: edge_n + L, tag: bus.req_tag});
            end
        end
        exp_ack  = (evq.size() != 0) && (evq[0].due == edge_n + 1);
        exp_tag  = exp_ack ? evq[0].tag : '0;
        exp_pend = evq.size();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            check("ack",      32'(bus.ack),      32'(exp_ack));
            check("ack_tag",  32'(bus.ack_tag),  32'(exp_tag));
            check("pending",  32'(bus.pending),  32'(exp_pend));
            check("ack_cnt",  32'(bus.ack_cnt),  32'(m_ack_cnt));
            check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop_cnt));
        end
    end

    // Returns at the negedge following edge k.
    task automatic wait_after(input int k);
        while (edge_n < k) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus + literal checks ----------------
    initial begin
        rst          = 1'b1;
        bus.req      = 1'b0;
        bus.req_tag  = '0;
        bus.drop_inj = 1'b0;
        bus.flush    = 1'b0;

        // reset state
        wait_after(1);
        check("rst_ack",      32'(bus.ack),      32'd0);
        check("rst_pending",  32'(bus.pending),  32'd0);
        check("rst_ack_cnt",  32'(bus.ack_cnt),  32'd0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        wait_after(2);
        rst = 1'b0;

        // 1: single req tag 5 at edge 3
        bus.req = 1'b1; bus.req_tag = 4'd5;
        wait_after(3);
        bus.req = 1'b0; bus.req_tag = '0;
        check("t1_ack_e4", 32'(bus.ack), 32'd0);
        check("t1_pend_e4", 32'(bus.pending), 32'd1);
        wait_after(4);
        check("t1_ack_e5", 32'(bus.ack), 32'd1);
        check("t1_tag_e5", 32'(bus.ack_tag), 32'd5);
        check("t1_pend_e5", 32'(bus.pending), 32'd1);
        wait_after(5);
        check("t1_ack_e6", 32'(bus.ack), 32'd0);
        check("t1_pend_e6", 32'(bus.pending), 32'd0);

        // 2: back-to-back reqs at edges 10..19, tags 0..9
        for (int i = 0; i < 10; i++) begin
            wait_after(9 + i);
            if (i == 2) check("t2_pend_e12", 32'(bus.pending), 32'd2);
            bus.req = 1'b1; bus.req_tag = 4'(i);
        end
        wait_after(19);
        bus.req = 1'b0; bus.req_tag = '0;
        check("t2_ack_e20", 32'(bus.ack), 32'd1);
        check("t2_tag_e20", 32'(bus.ack_tag), 32'd8);
        check("t2_pend_e20", 32'(bus.pending), 32'd2);
        wait_after(22);
        check("t2_ack_cnt", 32'(bus.ack_cnt), 32'd11);

        // 3: reqs at 30,31,32 with drop_inj at 31
        wait_after(29);
        bus.req = 1'b1; bus.req_tag = 4'd1;
        wait_after(30);
        bus.req_tag = 4'd2; bus.drop_inj = 1'b1;
        wait_after(31);
        bus.req_tag = 4'd3; bus.drop_inj = 1'b0;
        check("t3_ack_e32", 32'(bus.ack), 32'd1);
        check("t3_tag_e32", 32'(bus.ack_tag), 32'd1);
        check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        wait_after(32);
        bus.req = 1'b0; bus.req_tag = '0;
        check("t3_ack_e33", 32'(bus.ack), 32'd0);
        check("t3_tag_e33", 32'(bus.ack_tag), 32'd0);
        check("t3_pend_e33", 32'(bus.pending), 32'd1);
        wait_after(33);
        check("t3_ack_e34", 32'(bus.ack), 32'd1);
        check("t3_tag_e34", 32'(bus.ack_tag), 32'd3);

        // drop_inj without req is ignored
        wait_after(36);
        bus.drop_inj = 1'b1;
        wait_after(37);
        bus.drop_inj = 1'b0;
        check("idle_drop_cnt", 32'(bus.drop_cnt), 32'd1);

        // 4: reqs at 40,41, flush at 41
        wait_after(39);
        bus.req = 1'b1; bus.req_tag = 4'd4;
        wait_after(40);
        bus.req_tag = 4'd6; bus.flush = 1'b1;
        wait_after(41);
        bus.req = 1'b0; bus.req_tag = '0; bus.flush = 1'b0;
        check("t4_ack_e42", 32'(bus.ack), 32'd0);
        check("t4_pend", 32'(bus.pending), 32'd0);
        check("t4_ack_cnt", 32'(bus.ack_cnt), 32'd13);
        check("t4_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        wait_after(42);
        check("t4_ack_e43", 32'(bus.ack), 32'd0);

        // 5: reqs at 50,51, rst at 51
        wait_after(49);
        bus.req = 1'b1; bus.req_tag = 4'd7;
        wait_after(50);
        bus.req_tag = 4'd8; rst = 1'b1;
        wait_after(51);
        bus.req = 1'b0; bus.req_tag = '0; rst = 1'b0;
        check("t5_ack", 32'(bus.ack), 32'd0);
        check("t5_tag", 32'(bus.ack_tag), 32'd0);
        check("t5_pend", 32'(bus.pending), 32'd0);
        check("t5_ack_cnt", 32'(bus.ack_cnt), 32'd0);
        check("t5_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        wait_after(52);
        check("t5_ack_e53", 32'(bus.ack), 32'd0);
        check("t5_pend_e53", 32'(bus.pending), 32'd0);

        // 6: drive ack_cnt to FFFE with 65534 real requests, then wrap it
        for (int i = 0; i < 65534; i++) begin
            wait_after(59 + i);
            if (i == 1) check("t6_ack_e61", 32'(bus.ack), 32'd0);
            if (i == 2) begin
                check("t6_first_ack", 32'(bus.ack), 32'd1);
                check("t6_first_tag", 32'(bus.ack_tag), 32'd0);
            end
            bus.req = 1'b1; bus.req_tag = 4'(i);
        end
        wait_after(65593);
        bus.req = 1'b0; bus.req_tag = '0;
        wait_after(65599);
        check("t6_cnt_fffe", 32'(bus.ack_cnt), 32'h0000_FFFE);
        bus.req = 1'b1; bus.req_tag = 4'd9;
        wait_after(65600);
        bus.req_tag = 4'd10;
        wait_after(65601);
        bus.req_tag = 4'd11;
        wait_after(65602);
        bus.req = 1'b0; bus.req_tag = '0;
        check("t6_cnt_ffff", 32'(bus.ack_cnt), 32'h0000_FFFF);
        wait_after(65603);
        check("t6_cnt_0000", 32'(bus.ack_cnt), 32'h0000_0000);
        wait_after(65604);
        check("t6_cnt_0001", 32'(bus.ack_cnt), 32'h0000_0001);
        wait_after(65608);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
